// File: rtl/bus_pkg.sv
// Shared types and helpers for the multi-master bus arbiter and its data path.
package bus_pkg;

    localparam int SRC_ZERO = 0;

    typedef enum logic {
        IDLE,
        OWNED
    } arb_state_t;

    // Index of the first set bit of req at or above start, wrapping modulo n; returns start when req is empty.
    function automatic int rr_next(input logic [31:0] req, input int start, input int n);
        int  idx;
        logic found;
        rr_next = start;
        found   = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (i < n) begin
                idx = start + i;
                if (idx >= n) idx = idx - n;
                if (!found && req[idx[4:0]]) begin
                    rr_next = idx;
                    found   = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with bounded hold: one owner at a time, handover without idle cycles.
module rr_arbiter
    import bus_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int MAX_HOLD    = 8,
    localparam int IDX_W      = $clog2(NUM_MASTERS),
    localparam int HOLD_W     = $clog2(MAX_HOLD + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] req,
    output logic [NUM_MASTERS-1:0] gnt,
    output logic [IDX_W-1:0]       owner,
    output logic                   gnt_active
);

    arb_state_t              state, state_nxt;
    logic [NUM_MASTERS-1:0]  gnt_nxt;
    logic [IDX_W-1:0]        owner_nxt, owner_inc, rr_ptr, rr_ptr_nxt;
    logic [IDX_W-1:0]        win_idle, win_next;
    logic [HOLD_W-1:0]       hold_cnt, hold_nxt;
    logic [NUM_MASTERS-1:0]  others;

    function automatic logic [NUM_MASTERS-1:0] onehot(input logic [IDX_W-1:0] i);
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            gnt      <= '0;
            owner    <= '0;
            rr_ptr   <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            owner    <= owner_nxt;
            rr_ptr   <= rr_ptr_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    assign owner_inc  = (int'(owner) == NUM_MASTERS - 1) ? '0 : owner + 1'b1;
    // gnt is one-hot on the owner while OWNED, so this masks the owner out of req
    assign others     = req & ~gnt;
    assign win_idle   = IDX_W'(rr_next(32'(req), int'(rr_ptr), NUM_MASTERS));
    assign win_next   = IDX_W'(rr_next(32'(req), int'(owner_inc), NUM_MASTERS));
    assign gnt_active = (state == OWNED);

    always_comb begin
        state_nxt  = state;
        gnt_nxt    = gnt;
        owner_nxt  = owner;
        rr_ptr_nxt = rr_ptr;
        hold_nxt   = hold_cnt;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt = OWNED;
                    gnt_nxt   = onehot(win_idle);
                    owner_nxt = win_idle;
                    hold_nxt  = HOLD_W'(1);
                end
            end
            OWNED: begin
                if (!req[owner]) begin
                    rr_ptr_nxt = owner_inc;
                    if (|others) begin
                        gnt_nxt   = onehot(win_next);
                        owner_nxt = win_next;
                        hold_nxt  = HOLD_W'(1);
                    end else begin
                        state_nxt = IDLE;
                        gnt_nxt   = '0;
                    end
                end else if (hold_cnt == HOLD_W'(MAX_HOLD)) begin
                    hold_nxt = HOLD_W'(1);
                    if (|others) begin
                        rr_ptr_nxt = owner_inc;
                        gnt_nxt    = onehot(win_next);
                        owner_nxt  = win_next;
                    end
                end else begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/bus_arb.sv
// Shared data bus: the arbitrated owner's select picks a source slot, registered onto busout.
module bus_arb
    import bus_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int NUM_SRC     = 16,
    parameter int SEL_W       = 4,
    parameter int NUM_MASTERS = 4,
    parameter int MAX_HOLD    = 8,
    localparam int IDX_W      = $clog2(NUM_MASTERS)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_MASTERS-1:0]       req,
    input  logic [NUM_MASTERS*SEL_W-1:0] read_en,
    input  logic [NUM_SRC*WIDTH-1:0]     src_data,
    output logic [NUM_MASTERS-1:0]       gnt,
    output logic [WIDTH-1:0]             busout,
    output logic                         bus_valid,
    output logic [IDX_W-1:0]             bus_owner,
    output logic                         sel_err
);

    logic [IDX_W-1:0] owner;
    logic             gnt_active;
    logic [SEL_W-1:0] sel_idx;
    logic             sel_ok;
    logic [WIDTH-1:0] slot_word;

    rr_arbiter #(
        .NUM_MASTERS(NUM_MASTERS),
        .MAX_HOLD   (MAX_HOLD)
    ) u_arb (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .gnt       (gnt),
        .owner     (owner),
        .gnt_active(gnt_active)
    );

    assign sel_idx = read_en[int'(owner)*SEL_W +: SEL_W];
    assign sel_ok  = int'(sel_idx) < NUM_SRC;

    // Slot 0 is hard-wired to zero regardless of what the source vector carries there
    always_comb begin
        slot_word = '0;
        if (sel_ok && int'(sel_idx) != SRC_ZERO) begin
            slot_word = src_data[int'(sel_idx)*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busout    <= '0;
            bus_valid <= 1'b0;
            bus_owner <= '0;
            sel_err   <= 1'b0;
        end else if (gnt_active) begin
            bus_valid <= 1'b1;
            bus_owner <= owner;
            busout    <= slot_word;
            sel_err   <= !sel_ok;
        end else begin
            bus_valid <= 1'b0;
            sel_err   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bus_arb.sv
// Self-checking bench for bus_arb: directed scenarios plus randomized traffic against a behavioural model.
module tb_bus_arb;

    localparam int WIDTH = 16;
    localparam int NSRC  = 12;
    localparam int SELW  = 4;
    localparam int NM    = 4;
    localparam int HOLD  = 8;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [NM-1:0]     req = '0;
    logic [NM*SELW-1:0] read_en;
    logic [NSRC*WIDTH-1:0] src_data;
    logic [NM-1:0]     gnt;
    logic [WIDTH-1:0]  busout;
    logic              bus_valid;
    logic [1:0]        bus_owner;
    logic              sel_err;

    logic [SELW-1:0]   rd_sel [NM];
    logic [WIDTH-1:0]  src_mem [NSRC];

    int checks   = 0;
    int failures = 0;

    // reference model state (plain integers)
    bit m_active = 0;
    int m_owner  = 0;
    int m_hold   = 0;
    int m_ptr    = 0;
    logic [NM-1:0]    exp_gnt   = '0;
    logic [WIDTH-1:0] exp_bus   = '0;
    logic             exp_valid = 1'b0;
    logic [1:0]       exp_owner = '0;
    logic             exp_err   = 1'b0;

    always #5 clock = ~clock;

    always_comb begin
        for (int i = 0; i < NM; i++) read_en[i*SELW +: SELW] = rd_sel[i];
        for (int i = 0; i < NSRC; i++) src_data[i*WIDTH +: WIDTH] = src_mem[i];
    end

    bus_arb #(
        .WIDTH(WIDTH), .NUM_SRC(NSRC), .SEL_W(SELW), .NUM_MASTERS(NM), .MAX_HOLD(HOLD)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .read_en  (read_en),
        .src_data (src_data),
        .gnt      (gnt),
        .busout   (busout),
        .bus_valid(bus_valid),
        .bus_owner(bus_owner),
        .sel_err  (sel_err)
    );

    function automatic int search(input logic [NM-1:0] r, input int start);
        for (int i = 0; i < NM; i++) begin
            if (r[(start + i) % NM]) return (start + i) % NM;
        end
        return -1;
    endfunction

    task automatic model_edge();
        int w;
        int s;
        if (reset) begin
            m_active = 0; m_owner = 0; m_hold = 0; m_ptr = 0;
            exp_bus = '0; exp_valid = 0; exp_owner = '0; exp_err = 0;
        end else begin
            if (m_active) begin
                s = int'(rd_sel[m_owner]);
                exp_valid = 1;
                exp_owner = 2'(m_owner);
                if (s < NSRC) begin
                    exp_bus = (s == 0) ? '0 : src_mem[s];
                    exp_err = 0;
                end else begin
                    exp_bus = '0;
                    exp_err = 1;
                end
            end else begin
                exp_valid = 0;
                exp_err   = 0;
            end
            if (!m_active) begin
                w = search(req, m_ptr);
                if (w >= 0) begin m_active = 1; m_owner = w; m_hold = 1; end
            end else if (!req[m_owner]) begin
                m_ptr = (m_owner + 1) % NM;
                w = search(req, m_ptr);
                if (w >= 0) begin m_owner = w; m_hold = 1; end
                else m_active = 0;
            end else if (m_hold == HOLD) begin
                w = search(req & ~(NM'(1) << m_owner), (m_owner + 1) % NM);
                if (w >= 0) begin m_ptr = (m_owner + 1) % NM; m_owner = w; end
                m_hold = 1;
            end else begin
                m_hold++;
            end
        end
        exp_gnt = m_active ? (NM'(1) << m_owner) : '0;
    endtask

    task automatic check_all(input string tag);
        checks++;
        assert (gnt === exp_gnt) else begin
            failures++; $error("FAIL %s gnt observed=%b expected=%b", tag, gnt, exp_gnt);
        end
        checks++;
        assert (busout === exp_bus) else begin
            failures++; $error("FAIL %s busout observed=%h expected=%h", tag, busout, exp_bus);
        end
        checks++;
        assert (bus_valid === exp_valid) else begin
            failures++; $error("FAIL %s bus_valid observed=%b expected=%b", tag, bus_valid, exp_valid);
        end
        checks++;
        assert (bus_owner === exp_owner) else begin
            failures++; $error("FAIL %s bus_owner observed=%0d expected=%0d", tag, bus_owner, exp_owner);
        end
        checks++;
        assert (sel_err === exp_err) else begin
            failures++; $error("FAIL %s sel_err observed=%b expected=%b", tag, sel_err, exp_err);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clock);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        step("reset");
        step("reset");
        reset = 1'b0;
    endtask

    task automatic directed(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++; $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        for (int i = 0; i < NM; i++) rd_sel[i] = '0;
        for (int i = 0; i < NSRC; i++) src_mem[i] = WIDTH'($urandom);

        // single master
        do_reset();
        rd_sel[1] = 4'd5;
        src_mem[5] = 16'hA5A5;
        req = 4'b0010;
        step("single_grant");
        directed("single_gnt", 32'(gnt), 32'h2);
        step("single_data");
        directed("single_bus", 32'(busout), 32'hA5A5);
        directed("single_owner", 32'(bus_owner), 32'h1);
        req = '0;
        step("single_release");
        step("single_idle");

        // contention rotation: 8 cycles each, m0 first after reset
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 40; i++) begin
            step("rotate");
            directed("rotate_gnt", 32'(gnt), 32'(1) << ((i / HOLD) % NM));
            for (int m = 0; m < NM; m++) rd_sel[m] = SELW'($urandom_range(0, NSRC - 1));
        end

        // early release with wrap to m0
        do_reset();
        req = 4'b0100;
        step("early_own");
        req = 4'b0101;
        step("early_hold");
        step("early_hold");
        req = 4'b0001;
        step("early_release");
        directed("early_gnt", 32'(gnt), 32'h1);
        step("early_after");

        // sole requester keeps the bus through expiry
        do_reset();
        req = 4'b1000;
        rd_sel[3] = 4'd7;
        for (int i = 0; i < 20; i++) begin
            step("sole");
            directed("sole_gnt", 32'(gnt), 32'h8);
            if (i > 0) directed("sole_valid", 32'(bus_valid), 32'h1);
        end

        // bad select then slot 0
        rd_sel[3] = 4'd13;
        step("badsel");
        directed("badsel_err", 32'(sel_err), 32'h1);
        directed("badsel_bus", 32'(busout), 32'h0);
        rd_sel[3] = 4'd0;
        step("slot0");
        directed("slot0_err", 32'(sel_err), 32'h0);
        directed("slot0_bus", 32'(busout), 32'h0);

        // reset mid-ownership
        do_reset();
        rd_sel[1] = 4'd3;
        req = 4'b0010;
        step("midrst_own");
        step("midrst_data");
        step("midrst_data");
        reset = 1'b1;
        step("midrst_assert");
        directed("midrst_gnt", 32'(gnt), 32'h0);
        directed("midrst_valid", 32'(bus_valid), 32'h0);
        directed("midrst_bus", 32'(busout), 32'h0);
        reset = 1'b0;
        req = '0;
        step("midrst_idle");
        req = 4'b0110;
        step("midrst_regrant");
        directed("midrst_first", 32'(gnt), 32'h2);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) req = NM'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0)
                for (int m = 0; m < NM; m++) rd_sel[m] = SELW'($urandom);
            if ($urandom_range(0, 4) == 0) src_mem[$urandom_range(0, NSRC - 1)] = WIDTH'($urandom);
            reset = ($urandom_range(0, 99) == 0);
            step("random");
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
